tick_div_mc: RTL and testbench

TICK_DIV_MC -- requirements
Module: tick_div_mc

---
 rtl/tick_div_mc.sv | 89 ++++++++
 tb/tb_tick_div_mc.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tick_div_mc.sv
// Multi-channel programmable tick divider with glitch-free divisor update per channel.
// Optional phase-alignment input sync_in is enabled by defining TICK_DIV_MC_SYNC_EN.
module tick_div_mc #(
  parameter int unsigned CH      = 2,
  parameter int unsigned W       = 20,
  parameter int unsigned DEF_DIV = 200000,
  localparam int unsigned SW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          div_we,
  input  logic [SW-1:0] div_sel,
  input  logic [W-1:0]  div_val,
`ifdef TICK_DIV_MC_SYNC_EN
  input  logic          sync_in,
`endif
  output logic [CH-1:0] tick,
  output logic [CH-1:0] sq
);

  logic [W-1:0]  cnt   [CH];
  logic [W-1:0]  pend  [CH];
  logic [W-1:0]  act   [CH];
  logic [W-1:0]  d_eff [CH];
  logic [CH-1:0] pv;
  logic [CH-1:0] wrap;
  logic [CH-1:0] hit;
  logic [CH-1:0] syn;
  logic [CH-1:0] xfer;

  // Per-channel wrap detection, write decode and divisor-transfer points.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign d_eff[i] = (act[i] == '0) ? W'(1) : act[i];
    assign wrap[i]  = en[i] && (cnt[i] == d_eff[i] - W'(1));
    // Out-of-range div_sel never matches any channel index, so the write is dropped.
    assign hit[i]   = div_we && (32'(div_sel) == i);
`ifdef TICK_DIV_MC_SYNC_EN
    assign syn[i]   = sync_in && en[i];
`else
    assign syn[i]   = 1'b0;
`endif
    assign xfer[i]  = wrap[i] || !en[i] || syn[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= '0;
      sq   <= '0;
      pv   <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt[i]  <= '0;
        act[i]  <= W'(DEF_DIV);
        pend[i] <= W'(DEF_DIV);
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!en[i] || syn[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end else if (wrap[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          sq[i]   <= ~sq[i];
        end else begin
          cnt[i]  <= cnt[i] + W'(1);
          tick[i] <= 1'b0;
        end

        if (hit[i]) begin
          pend[i] <= div_val;
        end

        // A write landing on a transfer cycle bypasses pend and takes effect immediately.
        if (xfer[i]) begin
          if (hit[i]) begin
            act[i] <= div_val;
          end else if (pv[i]) begin
            act[i] <= pend[i];
          end
          pv[i] <= 1'b0;
        end else if (hit[i]) begin
          pv[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_div_mc.sv
// Directed bench for tick_div_mc: tick/sq timing captured as per-step bitmasks vs hand-computed patterns.
// A second CH=3 instance exercises an out-of-range div_sel, unrepresentable at CH=2.
module tb_tick_div_mc;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    en = '0;
  logic          div_we = 1'b0;
  logic [0:0]    div_sel = '0;
  logic [W-1:0]  div_val = '0;
  logic [1:0]    tick;
  logic [1:0]    sq;
  logic [2:0]    en3 = '0;
  logic          we3 = 1'b0;
  logic [1:0]    sel3 = '0;
  logic [W-1:0]  val3 = '0;
  logic [2:0]    tick3;
  logic [2:0]    sq3;
`ifdef TICK_DIV_MC_SYNC_EN
  logic          sync_in = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;
  int rel  = 0;
  int bad3 = 0;
  logic [31:0] m0, m1, s0, s1, m3;

  always #5 clk = ~clk;

  tick_div_mc #(.CH(2), .W(W), .DEF_DIV(5)) u_dut (
    .clk(clk), .rst(rst), .en(en), .div_we(div_we), .div_sel(div_sel), .div_val(div_val),
`ifdef TICK_DIV_MC_SYNC_EN
    .sync_in(sync_in),
`endif
    .tick(tick), .sq(sq)
  );

  tick_div_mc #(.CH(3), .W(W), .DEF_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en3), .div_we(we3), .div_sel(sel3), .div_val(val3),
`ifdef TICK_DIV_MC_SYNC_EN
    .sync_in(sync_in),
`endif
    .tick(tick3), .sq(sq3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_masks();
    rel = 0; m0 = '0; m1 = '0; s0 = '0; s1 = '0; m3 = '0; bad3 = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rel++;
      if (tick[0]) m0[rel] = 1'b1;
      if (tick[1]) m1[rel] = 1'b1;
      if (sq[0])   s0[rel] = 1'b1;
      if (sq[1])   s1[rel] = 1'b1;
      if (tick3 == 3'b111) m3[rel] = 1'b1;
      else if (tick3 != 3'b000) bad3++;
    end
  endtask

  task automatic wr(input logic sel, input logic [W-1:0] val);
    div_we = 1'b1; div_sel = sel; div_val = val;
    run(1);
    div_we = 1'b0;
  endtask

  initial begin
    clear_masks();
    // Reset state
    run(2);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_sq", 32'(sq), 32'h0);
    chk("rst_tick3", 32'(tick3), 32'h0);

    // Free-running at DEF_DIV=5 on both channels
    rst = 1'b0; en = 2'b11; clear_masks();
    run(20);
    chk("run5_tick0", m0, 32'h0010_8420);
    chk("run5_tick1", m1, 32'h0010_8420);
    chk("run5_sq0", s0, 32'h000F_83E0);
    chk("run5_sq1", s1, 32'h000F_83E0);

    // Divisor 3 written to ch0 at cnt=1: current period still 5, then 3
    clear_masks();
    run(1);
    wr(1'b0, 8'd3);
    run(12);
    chk("upd3_tick0", m0, 32'h0000_4920);
    chk("upd3_tick1", m1, 32'h0000_0420);

    // Divisors 0 and 1 loaded while disabled: tick every cycle
    en = 2'b00;
    run(1);
    chk("dis_tick", 32'(tick), 32'h0);
    wr(1'b0, 8'd0);
    wr(1'b1, 8'd1);
    en = 2'b11; clear_masks();
    run(6);
    chk("d0_tick0", m0, 32'h0000_007E);
    chk("d1_tick1", m1, 32'h0000_007E);
    chk("d0_sq0", s0, 32'h0000_002A);
    chk("d1_sq1", s1, 32'h0000_002A);

    // Write in the wrap cycle (bypass) and an out-of-range div_sel on the CH=3 instance
    en = 2'b00;
    wr(1'b0, 8'd4);
    wr(1'b1, 8'd5);
    en = 2'b11; en3 = 3'b111; we3 = 1'b1; sel3 = 2'd3; val3 = 8'd1;
    clear_masks();
    run(1);
    we3 = 1'b0;
    run(2);
    wr(1'b0, 8'd7);
    run(14);
    chk("wrapwr_tick0", m0, 32'h0004_0810);
    chk("wrapwr_tick1", m1, 32'h0000_8420);
    chk("oor_tick3", m3, 32'h0004_9248);
    chk("oor_split3", 32'(bad3), 32'h0);

    // Reset pulse mid-period aborts the period
    en = 2'b00;
    wr(1'b0, 8'd5);
    en = 2'b11; clear_masks();
    run(3);
    rst = 1'b1;
    run(1);
    chk("midrst_tick", 32'(tick), 32'h0);
    chk("midrst_sq", 32'(sq), 32'h0);
    rst = 1'b0; clear_masks();
    run(6);
    chk("postrst_tick0", m0, 32'h0000_0020);
    chk("postrst_tick1", m1, 32'h0000_0020);
    chk("postrst_sq0", s0, 32'h0000_0060);

`ifdef TICK_DIV_MC_SYNC_EN
    // Phase alignment: ch0 two cycles ahead of ch1, then one sync pulse
    en = 2'b00;
    wr(1'b0, 8'd4);
    wr(1'b1, 8'd4);
    en = 2'b01;
    run(2);
    en = 2'b11; sync_in = 1'b1; clear_masks();
    run(1);
    sync_in = 1'b0;
    run(5);
    chk("sync_tick0", m0, 32'h0000_0020);
    chk("sync_tick1", m1, 32'h0000_0020);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
